// File: rtl/mont_r2_pre_if.sv
// Handshake/data bundle for the Montgomery R^2 precompute block.
// The requester drives start and n; the engine returns r2 with busy/finish/err status.
// WIDTH must match the engine instance that is connected to it.
interface mont_r2_pre_if #(
   parameter int WIDTH = 2048
) ();
   logic             start;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] r2;
   logic             busy;
   logic             finish;
   logic             err;

   // Requester side: issues commands, observes result and status.
   modport master (
      output start,
      output n,
      input  r2,
      input  busy,
      input  finish,
      input  err
   );

   // Engine side: consumes commands, produces result and status.
   modport slave (
      input  start,
      input  n,
      output r2,
      output busy,
      output finish,
      output err
   );
endinterface

// File: rtl/mont_r2_pre.sv
// Computes r2 = 2^(2*WIDTH) mod n by 2*WIDTH shift-and-conditional-subtract steps.
// Latency: finish pulses 2*WIDTH cycles after the start edge; one cycle in the reject path.
// No backpressure: start is only sampled in IDLE, ignored otherwise. MONT_R2_PRE_CHECK_EN adds modulus checking.
module mont_r2_pre #(
   parameter int WIDTH = 2048
) (
   input  logic               clk,
   input  logic               sys_rst,
   mont_r2_pre_if.slave       bus
);

   // Counter must reach 2*WIDTH, so size it for 2*WIDTH+1 distinct values.
   localparam int            CW   = $clog2(2 * WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   acc_q,   acc_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] n_q,     n_d;
   logic [WIDTH-1:0] r2_q,    r2_d;

   logic [WIDTH:0]   dbl;
   logic [WIDTH:0]   n_ext;
   logic [WIDTH:0]   red;
   logic             reject;
   logic             busy_c;
   logic             finish_c;

   // One reduction step: acc < n_q holds, so the doubled value fits in WIDTH+1
   // bits and a single conditional subtraction brings it back below n_q.
   always_comb begin
      n_ext = {1'b0, n_q};
      dbl   = acc_q << 1;
      red   = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
   end

`ifdef MONT_R2_PRE_CHECK_EN
   logic err_q;

   // Even moduli and n < 3 have no Montgomery form; refuse them up front.
   always_comb begin
      reject = ~bus.n[0] | (bus.n < WIDTH'(3));
   end

   // err reflects the verdict on the most recently accepted start.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         err_q <= 1'b0;
      end else if ((state_q == IDLE) && bus.start) begin
         err_q <= reject;
      end
   end

   assign bus.err = err_q;
`else
   assign reject  = 1'b0;
   assign bus.err = 1'b0;
`endif

   // State and datapath registers; reset clears everything, including the result.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         r2_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         r2_q    <= r2_d;
      end
   end

   // Next-state, datapath updates and status outputs.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      r2_d     = r2_q;
      busy_c   = 1'b0;
      finish_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (reject) begin
                  // Rejected modulus: skip RUN, keep r2, just signal completion.
                  state_d = DONE;
               end else begin
                  n_d     = bus.n;
                  acc_d   = (WIDTH + 1)'(1);
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
         end

         RUN: begin
            busy_c = 1'b1;
            acc_d  = red;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               r2_d    = red[WIDTH-1:0];
               state_d = DONE;
            end
         end

         DONE: begin
            // start is deliberately not looked at here; it is picked up in IDLE.
            finish_c = 1'b1;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.r2     = r2_q;
   assign bus.busy   = busy_c;
   assign bus.finish = finish_c;

endmodule

// File: doc/mont_r2_pre.md
MONT_R2_PRE -- requirements
Module: mont_r2_pre

Interface
REQ-001 SHALL have parameter WIDTH, default 2048, operand/modulus width in bits; legal values: 4 or more.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new R2 computation; sampled only in IDLE.
REQ-005 SHALL have port n, input, WIDTH bits: modulus; captured on the accepted start edge.
REQ-006 SHALL have port r2, output, WIDTH bits: result 2^(2*WIDTH) mod n, the Montgomery conversion constant fed to the exponentiator.
REQ-007 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-008 SHALL have port finish, output, 1 bit: one-cycle pulse marking r2 valid.
REQ-009 SHALL have port err, output, 1 bit: modulus rejected; see REQ-027.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE.
REQ-011 In IDLE, start=1 at a rising edge SHALL do the following: latch n into n_q; set acc to 1 (WIDTH+1 bits); clear the iteration counter; set busy=1; enter RUN.
REQ-012 In IDLE, start=0 SHALL keep the state and all outputs unchanged.
REQ-013 In RUN, each edge SHALL compute t = acc<<1 and set acc to t-n_q if t >= n_q, else t.
REQ-014 In RUN, each edge SHALL increment the counter; the counter SHALL be wide enough to hold 2*WIDTH.
REQ-015 After exactly 2*WIDTH RUN iterations, the final acc[WIDTH-1:0] SHALL be written to r2, and the block SHALL enter DONE on the same edge.
REQ-016 In DONE, finish SHALL be 1 and busy SHALL be 0 for exactly one cycle; the next edge SHALL return to IDLE with finish=0.
REQ-017 Latency SHALL be as follows: finish is high in the cycle after the (2*WIDTH)-th edge following the start-sampling edge.
REQ-018 r2 SHALL hold its value from DONE until the next completed computation or reset.
REQ-019 Intermediate values SHALL use WIDTH+1 bits; with 1 < n_q, acc < n_q holds, so 2*acc never overflows.
REQ-020 start while busy or in DONE SHALL be ignored and not queued.
REQ-021 Changes on n after start is accepted SHALL NOT affect the current result.
REQ-022 Back-to-back operation SHALL be supported: start high in the IDLE cycle right after DONE launches a new run.

Reset
REQ-023 On sys_rst=1, the following SHALL take effect immediately, independent of clk: state=IDLE; r2=0, busy=0, finish=0, err=0; acc, n_q and counter cleared.
REQ-024 sys_rst asserted mid-RUN SHALL abort the computation with no finish pulse; r2 SHALL read 0.
REQ-025 After sys_rst deasserts, the first start SHALL be honoured on the first rising edge on which it is sampled high.

Configuration
REQ-026 Macro MONT_R2_PRE_CHECK_EN SHALL enable modulus validation.
REQ-027 With the macro defined, an IDLE start with n even or n < 3 SHALL set err=1, leave r2 unchanged, produce a one-cycle finish pulse on the next cycle without entering RUN, and clear err on the next accepted start.
REQ-028 Without the macro, err SHALL be tied to 0, n SHALL be unchecked, and results for illegal n are undefined.

Verification
REQ-029 WIDTH=8, n=13, start pulse: finish exactly 16 cycles after the start edge; r2=3 (65536 mod 13).
REQ-030 WIDTH=8, n=255: r2=1; with WIDTH=2048, n=2^2048-1: r2=1 and finish 4096 cycles after start.
REQ-031 WIDTH=8, n=13, start held high throughout, n changed to 11 mid-RUN: exactly one finish with r2=3; a second run then starts the cycle after DONE and yields r2 = 65536 mod 11 = 9.
REQ-032 WIDTH=8, sys_rst pulsed at cycle 5 of RUN: busy=0 and r2=0 asynchronously, no finish; a subsequent start with n=13 gives r2=3.
REQ-033 With MONT_R2_PRE_CHECK_EN, n=12 or n=1: err=1, finish pulse one cycle later, r2 unchanged; then n=13 gives err=0 and r2=3.
